exe_scheduler: RTL and testbench
================================

Name: exe_scheduler

Overview:
- Issue/writeback scheduler for the execute stage. Sits between decode and the combinational ALU and the multi-cycle MUL pipeline.
- Sends single-cycle ops to the ALU and MUL ops into a fixed-latency multiply pipe.
- Tracks in-flight MULs, stalls decode on RAW/WAW hazards against pending MUL destinations and on writeback-port conflicts.
- Drives the single register-file writeback port.

Parameters:
- MUL_LAT, 5, MUL issue-to-writeback latency in cycles; legal 2..8.
- REG_W, 5, register index width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  kill all in-flight work (exception/IRET)
- id_valid  in  1  decode presents an instruction
- id_op  in  14  opcode, shared op constants
- id_rd  in  REG_W  destination register
- id_rs1, id_rs2  in  REG_W  source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_wen  in  1  instruction writes rd
- id_ready  out  1  instruction accepted this cycle (combinational)
- alu_op  out  14  op to ALU; `ADD-class op on ALU issue, else 0
- alu_issue  out  1  ALU-class issue this cycle
- mul_issue  out  1  MUL issue this cycle, launches multiply pipe
- wb_valid  out  1  writeback this cycle (registered)
- wb_rd  out  REG_W  writeback register (registered)
- wb_sel  out  1  0 = ALU result, 1 = MUL result (registered)
- busy  out  1  any MUL in flight

Behaviour:
- Reset (async, reset_n=0): all slots invalid; wb_valid=0, wb_rd=0, wb_sel=0, busy=0. Combinational outputs follow from the idle state: id_ready=1 if id_valid, alu_op=0.
- Op classes:
  - MUL class: `MUL.
  - ALU class: `ADD, `SUB, `LDB, `LDW, `STB, `STW, `MOV.
  - Control class: `BEQ, `JUMP, `TLBWRITE, `IRET. Issues in one cycle, never writes back here.
  - Unknown op: treated as control class.
- rd=0: effective wen forced 0; never tracked, never written back.
- Issue: fire = id_valid & id_ready. ALU class with fire → alu_issue=1, alu_op=id_op. MUL with fire → mul_issue=1.
- Tracking: shift register slot[0..MUL_LAT-1] of {valid, rd, wen}, advancing every cycle.
  - A MUL fired in cycle t occupies slot[0] in t+1 … slot[MUL_LAT-1] in t+MUL_LAT.
  - busy = OR of slot valids.
- Writeback (registered):
  - ALU class fired in t with wen → wb_valid=1, wb_sel=0 during t+1.
  - MUL fired in t with wen → wb_valid=1, wb_sel=1, wb_rd=rd during t+MUL_LAT.
  - Otherwise wb_valid=0 and wb_rd/wb_sel hold their previous values.
- Stall (id_ready=0) if any of:
  - RAW: a used source equals rd of any slot with valid&wen, including slot[MUL_LAT-1].
  - WAW: id_wen and id_rd equals rd of any valid&wen slot.
  - Port conflict: ALU class with id_wen while slot[MUL_LAT-2] is valid&wen. The older MUL has priority.
  - flush=1.
- Not hazards: MUL after MUL to independent registers (distinct writeback cycles); ALU-to-ALU dependencies (handled by the bypass network).
- Flush: synchronous. On the next edge all slots are cleared and wb_valid=0. No issue occurs in the flush cycle.
- Simultaneous events:
  - flush overrides issue.
  - Async reset mid-MUL discards everything; no late wb_valid after reset release.
- Port conflicts are prevented structurally: at most one wb source per cycle. Verification asserts this never fails.

Decomposition:
- Shared include (op constants file) gains MUL_LAT_DEF, WB_SEL_ALU=0, WB_SEL_MUL=1.
- Also in the shared include: op-class decode as a constant function or macro, reused by decode.
- One sub-module is natural: mul_tracker (slot shift register + rd match outputs: raw_hit, waw_hit, conflict_next).
- Issue/stall logic and wb registers stay in exe_scheduler.

Test Plan:
- Reset: assert reset_n=0 mid-run with a MUL in flight → wb_valid=0, busy=0, no wb_valid in the MUL_LAT cycles after release; idle id_valid=1 gives id_ready=1.
- Single MUL r3 fired cycle 0 (MUL_LAT=5) → wb_valid=1, wb_rd=3, wb_sel=1 in cycle 5 only; busy=1 in cycles 1..5.
- RAW: MUL r3 cycle 0, ADD r4 rs1=r3 offered cycle 1 → id_ready=0 cycles 1..5; fires cycle 6; wb_rd=4, wb_sel=0 cycle 7.
- Port conflict: MUL r3 cycle 0, independent ADD r7 offered cycle 4 → stalled cycle 4, fires cycle 5; wb r3 in cycle 5, wb r7 in cycle 6.
- Back-to-back MUL r1, r2, r3 in cycles 0..2 → no stall; wb_rd 1, 2, 3 in cycles 5, 6, 7 with wb_sel=1.
- Flush: MUL r5 cycle 0, flush=1 cycle 2 with ADD r6 offered → ADD not fired cycle 2; no wb for r5 ever; busy=0 from cycle 3; ADD fires cycle 3.

Source files
------------

// File: rtl/exe_scheduler_pkg.sv
// Shared op constants, writeback select codes and op-class decode for the execute stage.
// Ops are one-hot; any other encoding, including all-zero, decodes as control class.
package exe_scheduler_pkg;

  localparam int OP_W        = 14;
  localparam int REG_W_DEF   = 5;
  localparam int MUL_LAT_DEF = 5;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MUL = 1'b1;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD      = 14'h0001;
  localparam op_t OP_SUB      = 14'h0002;
  localparam op_t OP_LDB      = 14'h0004;
  localparam op_t OP_LDW      = 14'h0008;
  localparam op_t OP_STB      = 14'h0010;
  localparam op_t OP_STW      = 14'h0020;
  localparam op_t OP_MOV      = 14'h0040;
  localparam op_t OP_MUL      = 14'h0080;
  localparam op_t OP_BEQ      = 14'h0100;
  localparam op_t OP_JUMP     = 14'h0200;
  localparam op_t OP_TLBWRITE = 14'h0400;
  localparam op_t OP_IRET     = 14'h0800;

  typedef enum logic [1:0] {
    CLS_CTRL = 2'd0,
    CLS_ALU  = 2'd1,
    CLS_MUL  = 2'd2
  } op_class_e;

  function automatic op_class_e op_class(input op_t op);
    op_class_e cls;
    case (op)
      OP_MUL:  cls = CLS_MUL;
      OP_ADD, OP_SUB, OP_LDB, OP_LDW,
      OP_STB, OP_STW, OP_MOV: cls = CLS_ALU;
      default: cls = CLS_CTRL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/exe_scheduler_if.sv
// Decode-to-execute handshake plus the scheduler's issue and writeback outputs.
interface exe_scheduler_if
  import exe_scheduler_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) ();

  logic             id_valid;
  op_t              id_op;
  logic [REG_W-1:0] id_rd;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             id_wen;
  logic             id_ready;
  op_t              alu_op;
  logic             alu_issue;
  logic             mul_issue;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic             wb_sel;
  logic             busy;

  modport master (
    output id_valid, id_op, id_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_wen,
    input  id_ready, alu_op, alu_issue, mul_issue, wb_valid, wb_rd, wb_sel, busy
  );

  modport slave (
    input  id_valid, id_op, id_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_wen,
    output id_ready, alu_op, alu_issue, mul_issue, wb_valid, wb_rd, wb_sel, busy
  );

endinterface

// File: rtl/exe_scheduler_mul_tracker.sv
// Shift register of in-flight MULs; flags operand hazards and the MUL writeback due next cycle.
module exe_scheduler_mul_tracker
  import exe_scheduler_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int REG_W   = REG_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [REG_W-1:0] push_rd,
  input  logic             push_wen,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wen,
  output logic             raw_hit,
  output logic             waw_hit,
  output logic             conflict_next,
  output logic [REG_W-1:0] conflict_rd,
  output logic             busy
);

  logic [MUL_LAT-1:0] slot_valid;
  logic [MUL_LAT-1:0] slot_wen;
  logic [REG_W-1:0]   slot_rd [MUL_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= '0;
      slot_wen   <= '0;
      for (int i = 0; i < MUL_LAT; i++) slot_rd[i] <= '0;
    end else if (flush) begin
      slot_valid <= '0;
      slot_wen   <= '0;
    end else begin
      slot_valid <= {slot_valid[MUL_LAT-2:0], push};
      slot_wen   <= {slot_wen[MUL_LAT-2:0], push & push_wen};
      slot_rd[0] <= push_rd;
      for (int i = 1; i < MUL_LAT; i++) slot_rd[i] <= slot_rd[i-1];
    end
  end

  // The last slot still counts: its result lands on the port this cycle, too late to bypass.
  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) begin
      if (slot_wen[i]) begin
        if ((rs1_used && rs1 == slot_rd[i]) || (rs2_used && rs2 == slot_rd[i])) raw_hit = 1'b1;
        if (id_wen && id_rd == slot_rd[i]) waw_hit = 1'b1;
      end
    end
  end

  assign conflict_next = slot_wen[MUL_LAT-2];
  assign conflict_rd   = slot_rd[MUL_LAT-2];
  assign busy          = |slot_valid;

endmodule

// File: rtl/exe_scheduler.sv
// Execute-stage issue/writeback scheduler: routes ops to the ALU or MUL pipe, stalls decode
// on hazards against in-flight MULs, and owns the single register-file writeback port.
module exe_scheduler
  import exe_scheduler_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int REG_W   = REG_W_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  exe_scheduler_if.slave sched
);

  op_class_e        op_cls;
  logic             wen_eff;
  logic             raw_hit;
  logic             waw_hit;
  logic             conflict_next;
  logic [REG_W-1:0] conflict_rd;
  logic             port_stall;
  logic             fire;
  logic             alu_fire;
  logic             mul_fire;
  logic             alu_wb;
  logic             wb_valid_q;
  logic [REG_W-1:0] wb_rd_q;
  logic             wb_sel_q;

  assign op_cls  = op_class(sched.id_op);
  assign wen_eff = sched.id_wen & (sched.id_rd != '0);

  // An older MUL owns the port next cycle, so a writing ALU op waits one cycle.
  assign port_stall = (op_cls == CLS_ALU) & wen_eff & conflict_next;
  assign fire       = sched.id_valid & ~flush & ~raw_hit & ~waw_hit & ~port_stall;
  assign alu_fire   = fire & (op_cls == CLS_ALU);
  assign mul_fire   = fire & (op_cls == CLS_MUL);
  assign alu_wb     = alu_fire & wen_eff;

  exe_scheduler_mul_tracker #(
    .MUL_LAT (MUL_LAT),
    .REG_W   (REG_W)
  ) u_mul_tracker (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .push          (mul_fire),
    .push_rd       (sched.id_rd),
    .push_wen      (wen_eff),
    .rs1           (sched.id_rs1),
    .rs2           (sched.id_rs2),
    .rs1_used      (sched.id_rs1_used),
    .rs2_used      (sched.id_rs2_used),
    .id_rd         (sched.id_rd),
    .id_wen        (wen_eff),
    .raw_hit       (raw_hit),
    .waw_hit       (waw_hit),
    .conflict_next (conflict_next),
    .conflict_rd   (conflict_rd),
    .busy          (sched.busy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_sel_q   <= WB_SEL_ALU;
    end else if (flush) begin
      wb_valid_q <= 1'b0;
    end else if (conflict_next) begin
      wb_valid_q <= 1'b1;
      wb_rd_q    <= conflict_rd;
      wb_sel_q   <= WB_SEL_MUL;
    end else if (alu_wb) begin
      wb_valid_q <= 1'b1;
      wb_rd_q    <= sched.id_rd;
      wb_sel_q   <= WB_SEL_ALU;
    end else begin
      wb_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) assert (!(alu_wb && conflict_next));
  end

  assign sched.id_ready  = fire;
  assign sched.alu_issue = alu_fire;
  assign sched.alu_op    = alu_fire ? sched.id_op : '0;
  assign sched.mul_issue = mul_fire;
  assign sched.wb_valid  = wb_valid_q;
  assign sched.wb_rd     = wb_rd_q;
  assign sched.wb_sel    = wb_sel_q;

endmodule

// File: tb/tb_exe_scheduler.sv
// Directed and random checks of exe_scheduler against a time-stamped list of in-flight MULs.
module tb_exe_scheduler;
  import exe_scheduler_pkg::*;

  localparam int LAT = 5;
  localparam int RW  = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  exe_scheduler_if #(.REG_W(RW)) bus ();

  exe_scheduler #(.MUL_LAT(LAT), .REG_W(RW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .sched   (bus)
  );

  typedef struct {
    int       t;
    logic [4:0] rd;
    bit       wen;
  } mul_rec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  mul_rec_t pend[$];
  bit         sv [16];
  logic [4:0] srd [16];
  bit         ssel [16];
  logic [4:0] last_rd = '0;
  bit         last_sel = 1'b0;
  logic [4:0] wb_log[$];
  bit         last_ready;
  op_t        ops [12] = '{OP_ADD, OP_SUB, OP_LDB, OP_LDW, OP_STB, OP_STW, OP_MOV,
                           OP_MUL, OP_BEQ, OP_JUMP, OP_TLBWRITE, OP_IRET};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // 2 = multiply, 1 = single-cycle ALU, 0 = control or unknown
  function automatic int cls_of(input op_t op);
    case (op)
      OP_MUL: return 2;
      OP_ADD, OP_SUB, OP_LDB, OP_LDW, OP_STB, OP_STW, OP_MOV: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic drive(input bit v, input op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit u1, input bit u2, input bit wen, input bit fl);
    bus.id_valid = v;     bus.id_op = op;       bus.id_rd = rd;
    bus.id_rs1 = rs1;     bus.id_rs2 = rs2;     bus.id_rs1_used = u1;
    bus.id_rs2_used = u2; bus.id_wen = wen;     flush = fl;
  endtask

  task automatic clear_model();
    pend.delete();
    for (int i = 0; i < 16; i++) sv[i] = 1'b0;
  endtask

  task automatic step();
    bit raw = 0, waw = 0, cfl = 0, bsy = 0, rdy, wen_e;
    int c, k;
    @(negedge clk);
    c = cls_of(bus.id_op);
    wen_e = bus.id_wen && (bus.id_rd != 0);
    foreach (pend[i]) begin
      if (pend[i].t < cyc && cyc <= pend[i].t + LAT) begin
        bsy = 1;
        if (pend[i].wen) begin
          if ((bus.id_rs1_used && bus.id_rs1 == pend[i].rd) ||
              (bus.id_rs2_used && bus.id_rs2 == pend[i].rd)) raw = 1;
          if (wen_e && bus.id_rd == pend[i].rd) waw = 1;
          if (c == 1 && wen_e && pend[i].t + LAT == cyc + 1) cfl = 1;
        end
      end
    end
    rdy = bus.id_valid && !flush && !raw && !waw && !cfl;
    k = cyc % 16;
    chk("id_ready", bus.id_ready, rdy);
    chk("alu_issue", bus.alu_issue, rdy && c == 1);
    chk("alu_op", bus.alu_op, (rdy && c == 1) ? bus.id_op : 14'h0);
    chk("mul_issue", bus.mul_issue, rdy && c == 2);
    chk("busy", bus.busy, bsy);
    chk("wb_valid", bus.wb_valid, sv[k]);
    if (sv[k]) begin
      last_rd = srd[k];
      last_sel = ssel[k];
    end
    chk("wb_rd", bus.wb_rd, last_rd);
    chk("wb_sel", bus.wb_sel, last_sel);
    if (bus.wb_valid) wb_log.push_back(bus.wb_rd);
    last_ready = bus.id_ready;
    sv[k] = 1'b0;
    if (flush) begin
      clear_model();
    end else if (rdy && c == 1 && wen_e) begin
      sv[(cyc + 1) % 16] = 1'b1; srd[(cyc + 1) % 16] = bus.id_rd; ssel[(cyc + 1) % 16] = 1'b0;
    end else if (rdy && c == 2) begin
      pend.push_back('{cyc, bus.id_rd, wen_e});
      if (wen_e) begin
        sv[(cyc + LAT) % 16] = 1'b1; srd[(cyc + LAT) % 16] = bus.id_rd; ssel[(cyc + LAT) % 16] = 1'b1;
      end
    end
    while (pend.size() > 0 && pend[0].t + LAT < cyc + 1) void'(pend.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    drive(0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    drive(1, OP_ADD, 5'd1, 0, 0, 0, 0, 1, 0);
    reset_n = 1'b0;
    #2;
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_wb_sel", bus.wb_sel, 0);
    chk("rst_id_ready", bus.id_ready, 1);
    clear_model();
    last_rd = '0;
    last_sel = 1'b0;
    @(negedge clk);
    bus.id_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic offer_until_ready(output int stalls);
    stalls = 0;
    step();
    while (!last_ready && stalls < 20) begin
      stalls++;
      step();
    end
  endtask

  initial begin
    int stalls;
    drive(0, OP_ADD, 0, 0, 0, 0, 0, 0, 0);
    #1;
    do_reset();

    // single MUL
    wb_log.delete();
    drive(1, OP_MUL, 5'd3, 5'd1, 5'd2, 1, 1, 1, 0); step();
    idle(LAT + 2);
    chk("mul_wb_count", wb_log.size(), 1);
    if (wb_log.size() == 1) chk("mul_wb_rd", wb_log[0], 3);

    // RAW on a pending MUL destination
    wb_log.delete();
    drive(1, OP_MUL, 5'd3, 0, 0, 0, 0, 1, 0); step();
    drive(1, OP_ADD, 5'd4, 5'd3, 5'd0, 1, 0, 1, 0);
    offer_until_ready(stalls);
    chk("raw_stall_cycles", stalls, 5);
    idle(3);
    chk("raw_wb_count", wb_log.size(), 2);
    if (wb_log.size() == 2) chk("raw_wb_order", {wb_log[0], wb_log[1]}, {5'd3, 5'd4});

    // writeback port conflict
    wb_log.delete();
    drive(1, OP_MUL, 5'd3, 0, 0, 0, 0, 1, 0); step();
    idle(3);
    drive(1, OP_ADD, 5'd7, 5'd1, 5'd2, 1, 1, 1, 0);
    offer_until_ready(stalls);
    chk("port_stall_cycles", stalls, 1);
    idle(3);
    chk("port_wb_count", wb_log.size(), 2);
    if (wb_log.size() == 2) chk("port_wb_order", {wb_log[0], wb_log[1]}, {5'd3, 5'd7});

    // back-to-back independent MULs
    wb_log.delete();
    for (int r = 1; r <= 3; r++) begin
      drive(1, OP_MUL, r[4:0], 0, 0, 0, 0, 1, 0);
      step();
      chk("b2b_ready", last_ready, 1);
    end
    idle(LAT + 3);
    chk("b2b_wb_count", wb_log.size(), 3);
    if (wb_log.size() == 3) chk("b2b_wb_order", {wb_log[0], wb_log[1], wb_log[2]}, {5'd1, 5'd2, 5'd3});

    // flush kills the pending MUL and blocks issue for one cycle
    wb_log.delete();
    drive(1, OP_MUL, 5'd5, 0, 0, 0, 0, 1, 0); step();
    idle(1);
    drive(1, OP_ADD, 5'd6, 0, 0, 0, 0, 1, 1); step();
    chk("flush_no_issue", last_ready, 0);
    drive(1, OP_ADD, 5'd6, 0, 0, 0, 0, 1, 0); step();
    chk("post_flush_issue", last_ready, 1);
    idle(LAT + 2);
    chk("flush_wb_count", wb_log.size(), 1);
    if (wb_log.size() == 1) chk("flush_wb_rd", wb_log[0], 6);

    // async reset with a MUL in flight
    wb_log.delete();
    drive(1, OP_MUL, 5'd2, 0, 0, 0, 0, 1, 0); step();
    idle(2);
    do_reset();
    idle(LAT + 1);
    chk("reset_no_late_wb", wb_log.size(), 0);

    // random traffic, small register range so hazards are frequent
    for (int n = 0; n < 800; n++) begin
      int idx;
      op_t op;
      idx = $urandom_range(0, 12);
      op = (idx == 12) ? op_t'($urandom) : ops[idx];
      drive($urandom_range(0, 9) < 7, op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 24) == 0);
      step();
    end
    idle(LAT + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
